// File: rtl/axi_mem_tester_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_mem_tester_if : AXI4 bus bundle between tester and slave      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface axi_mem_tester_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 4
) ();
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface
`default_nettype wire

// File: rtl/axi_mem_tester.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_mem_tester : AXI4 burst write / read-back / compare initiator |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module axi_mem_tester #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 4,
   parameter int BURST_LEN  = 16,
   parameter int NUM_BURSTS = 4
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  start_i,
   input  wire logic [ADDR_WIDTH-1:0] base_addr_i,
   input  wire logic [31:0]           seed_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       pass_o,
   output logic [15:0]                err_count_o,
   output logic [ADDR_WIDTH-1:0]      first_err_addr_o,
   axi_mem_tester_if.master           m_axi
);
   localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int WORDS   = DATA_WIDTH / 32;
   localparam logic [BEAT_W-1:0]     C_LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
   localparam logic [BURST_W-1:0]    C_LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
   localparam logic [ADDR_WIDTH-1:0] C_BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);
   localparam logic [2:0]            C_SIZE        = 3'($clog2(STRB_WIDTH));

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_ADDR = 3'd1,
      S_WR_DATA = 3'd2,
      S_WR_RESP = 3'd3,
      S_RD_ADDR = 3'd4,
      S_RD_DATA = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [BURST_W-1:0]    burst_q, burst_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [31:0]           seed_q, seed_d;
   logic [31:0]           pat_q, pat_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
   logic                  pass_q, pass_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;

   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                  beat_last, b_err, r_err;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  unused_ids;

   // The same running word drives write data and the read-back compare.
   assign exp_data  = {WORDS{pat_q}};
   assign beat_last = (beat_q == C_LAST_BEAT);
   assign beat_addr = addr_q + (ADDR_WIDTH'(beat_q) << C_SIZE);

   assign aw_hs = awvalid_q && m_axi.awready;
   assign w_hs  = wvalid_q && m_axi.wready;
   assign b_hs  = m_axi.bvalid && m_axi.bready;
   assign ar_hs = arvalid_q && m_axi.arready;
   assign r_hs  = m_axi.rvalid && m_axi.rready;

   assign b_err = b_hs && (m_axi.bresp != 2'b00);
   assign r_err = r_hs && ((m_axi.rresp != 2'b00) || (m_axi.rdata != exp_data) ||
                           (m_axi.rlast != beat_last));

   always_comb begin
      state_d     = state_q;
      burst_d     = burst_q;
      beat_d      = beat_q;
      addr_d      = addr_q;
      base_d      = base_q;
      seed_d      = seed_q;
      pat_d       = pat_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;

      // A zero count means no error has been captured yet this run.
      if (b_err || r_err) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         if (err_cnt_q == 16'd0)    first_err_d = b_err ? addr_q : beat_addr;
      end

      unique case (state_q)
         S_IDLE: if (start_i) begin
            state_d     = S_WR_ADDR;
            base_d      = base_addr_i;
            seed_d      = seed_i;
            addr_d      = base_addr_i;
            pat_d       = seed_i;
            burst_d     = '0;
            beat_d      = '0;
            err_cnt_d   = '0;
            first_err_d = '0;
            pass_d      = 1'b0;
            awvalid_d   = 1'b1;
         end
         S_WR_ADDR: if (aw_hs) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b1;
            beat_d    = '0;
            state_d   = S_WR_DATA;
         end
         S_WR_DATA: if (w_hs) begin
            pat_d = pat_q + 32'd1;
            if (beat_last) begin
               beat_d   = '0;
               wvalid_d = 1'b0;
               state_d  = S_WR_RESP;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_WR_RESP: if (b_hs) begin
            if (burst_q == C_LAST_BURST) begin
               burst_d   = '0;
               addr_d    = base_q;
               pat_d     = seed_q;
               arvalid_d = 1'b1;
               state_d   = S_RD_ADDR;
            end else begin
               burst_d   = burst_q + BURST_W'(1);
               addr_d    = addr_q + C_BURST_BYTES;
               awvalid_d = 1'b1;
               state_d   = S_WR_ADDR;
            end
         end
         S_RD_ADDR: if (ar_hs) begin
            arvalid_d = 1'b0;
            beat_d    = '0;
            state_d   = S_RD_DATA;
         end
         S_RD_DATA: if (r_hs) begin
            pat_d = pat_q + 32'd1;
            if (beat_last) begin
               beat_d = '0;
               if (burst_q == C_LAST_BURST) begin
                  pass_d  = (err_cnt_d == 16'd0);
                  state_d = S_DONE;
               end else begin
                  burst_d   = burst_q + BURST_W'(1);
                  addr_d    = addr_q + C_BURST_BYTES;
                  arvalid_d = 1'b1;
                  state_d   = S_RD_ADDR;
               end
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         burst_q     <= '0;
         beat_q      <= '0;
         addr_q      <= '0;
         base_q      <= '0;
         seed_q      <= '0;
         pat_q       <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         pass_q      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_q     <= burst_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         seed_q      <= seed_d;
         pat_q       <= pat_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         pass_q      <= pass_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
      end
   end

   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = (state_q == S_DONE);
   assign pass_o           = pass_q;
   assign err_count_o      = err_cnt_q;
   assign first_err_addr_o = first_err_q;

   assign m_axi.awid    = ID_WIDTH'(0);
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = 8'(BURST_LEN - 1);
   assign m_axi.awsize  = C_SIZE;
   assign m_axi.awburst = 2'b01;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = 4'b0011;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;

   assign m_axi.wdata   = exp_data;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wvalid_q && beat_last;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = (state_q == S_WR_RESP);

   assign m_axi.arid    = ID_WIDTH'(0);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = 8'(BURST_LEN - 1);
   assign m_axi.arsize  = C_SIZE;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = 4'b0011;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = (state_q == S_RD_DATA);

   // Response IDs carry no information with a single outstanding burst.
   assign unused_ids = ^{m_axi.bid, m_axi.rid};
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_tester.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_mem_tester : directed bench with behavioural AXI slave     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_axi_mem_tester;
   localparam int DW = 512;
   localparam int AW = 16;
   localparam int SW = 64;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_i = '0;
   logic [31:0]   seed_i = '0;
   logic          busy, done, pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err;

   axi_mem_tester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) axi ();

   axi_mem_tester #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
      .BURST_LEN(16), .NUM_BURSTS(4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start_i),
      .base_addr_i      (base_i),
      .seed_i           (seed_i),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .err_count_o      (err_count),
      .first_err_addr_o (first_err),
      .m_axi            (axi)
   );

   always #5 clk = ~clk;

   // Fault-injection settings for the slave; -1 disables a setting.
   int          cfg_bp, cfg_corrupt, cfg_corrupt2, cfg_rresp, cfg_slverr, cfg_bad_rlast;
   logic [31:0] cfg_seed;

   logic [DW-1:0] mem [0:1023];
   logic [AW-1:0] aw_base, ar_base, aw_prev, ar_prev;
   logic [AW-1:0] aw_log [0:7];
   logic [DW-1:0] w_prev;
   logic          w_last_prev, aw_stall, w_stall, ar_stall;
   logic          b_pend, r_active;
   int            wbeat, wcount, bcount, rbeat, rk, aw_n, wbad, stall_bad;
   int            cyc = 0;
   int            r_hs_cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic logic [DW-1:0] pat(input logic [31:0] s, input int k);
      return {16{s + 32'(k)}};
   endfunction

   function automatic int idx(input logic [AW-1:0] a, input int beat);
      logic [9:0] i;
      i = a[15:6] + beat[9:0];
      return int'(i);
   endfunction

   function automatic logic rnd();
      return (cfg_bp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0;
         axi.bvalid <= 1'b0; axi.bresp <= 2'b00; axi.bid <= '0;
         axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rlast <= 1'b0; axi.rdata <= '0; axi.rid <= '0;
         wbeat <= 0; wcount <= 0; bcount <= 0; rbeat <= 0; rk <= 0; aw_n <= 0;
         wbad <= 0; stall_bad <= 0; b_pend <= 1'b0; r_active <= 1'b0;
         aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
      end else begin
         axi.awready <= rnd();
         axi.wready  <= rnd();
         axi.arready <= rnd();

         // A valid that was stalled last cycle must still be up with the same payload.
         if (aw_stall && (!axi.awvalid || axi.awaddr !== aw_prev)) stall_bad <= stall_bad + 1;
         if (w_stall && (!axi.wvalid || axi.wdata !== w_prev || axi.wlast !== w_last_prev))
            stall_bad <= stall_bad + 1;
         if (ar_stall && (!axi.arvalid || axi.araddr !== ar_prev)) stall_bad <= stall_bad + 1;
         aw_stall <= axi.awvalid && !axi.awready; aw_prev <= axi.awaddr;
         w_stall  <= axi.wvalid && !axi.wready;   w_prev  <= axi.wdata; w_last_prev <= axi.wlast;
         ar_stall <= axi.arvalid && !axi.arready; ar_prev <= axi.araddr;

         if (axi.awvalid && axi.awready) begin
            aw_base <= axi.awaddr;
            wbeat   <= 0;
            if (aw_n < 8) aw_log[aw_n] <= axi.awaddr;
            aw_n <= aw_n + 1;
         end
         if (axi.wvalid && axi.wready) begin
            mem[idx(aw_base, wbeat)] <= axi.wdata;
            if (axi.wdata !== pat(cfg_seed, wcount) || axi.wlast !== (wbeat == 15)) wbad <= wbad + 1;
            wcount <= wcount + 1;
            wbeat  <= wbeat + 1;
            if (wbeat == 15) b_pend <= 1'b1;
         end
         if (axi.bvalid && axi.bready) begin
            axi.bvalid <= 1'b0;
            bcount     <= bcount + 1;
         end else if (b_pend && !axi.bvalid && rnd()) begin
            axi.bvalid <= 1'b1;
            axi.bresp  <= (bcount == cfg_slverr) ? 2'b10 : 2'b00;
            b_pend     <= 1'b0;
         end

         if (axi.arvalid && axi.arready) begin
            ar_base  <= axi.araddr;
            r_active <= 1'b1;
            rbeat    <= 0;
         end
         if (axi.rvalid && axi.rready) begin
            axi.rvalid <= 1'b0;
            r_hs_cyc   <= cyc;
         end
         if (r_active && (!axi.rvalid || axi.rready) && rnd()) begin
            axi.rvalid <= 1'b1;
            axi.rdata  <= mem[idx(ar_base, rbeat)] ^
                          ((rk == cfg_corrupt || rk == cfg_corrupt2) ? DW'(1) : DW'(0));
            axi.rresp  <= (rk == cfg_rresp) ? 2'b10 : 2'b00;
            axi.rlast  <= (rbeat == 15) ^ (rk == cfg_bad_rlast);
            rk         <= rk + 1;
            rbeat      <= rbeat + 1;
            if (rbeat == 15) r_active <= 1'b0;
         end
      end
   end

   typedef struct {
      logic [15:0] base;
      logic [31:0] seed;
      int          bp;
      int          corrupt;
      int          corrupt2;
      int          rresp_k;
      int          slverr;
      int          bad_rlast;
      int          poke;
      int          exp_err;
      logic [15:0] exp_first;
      logic        exp_pass;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_cfg();
      cfg_bp = 0; cfg_corrupt = -1; cfg_corrupt2 = -1; cfg_rresp = -1;
      cfg_slverr = -1; cfg_bad_rlast = -1; cfg_seed = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits at negedges for done; optionally pulses a bogus start mid-run.
   task automatic wait_done(input int poke, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         start_i = (poke != 0 && c == 30);
         if (start_i) begin
            base_i = 16'h8000;
            seed_i = 32'h0;
         end
         @(negedge clk);
      end
      start_i = 1'b0;
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({busy, done, pass, err_count, first_err, axi.awvalid, axi.wvalid,
                  axi.wlast, axi.bready, axi.arvalid, axi.rready});
   endfunction

   task automatic run_vec(input int n, input vec_t v);
      bit            seen;
      logic [15:0]   exp_a;
      cfg_bp = v.bp; cfg_corrupt = v.corrupt; cfg_corrupt2 = v.corrupt2; cfg_rresp = v.rresp_k;
      cfg_slverr = v.slverr; cfg_bad_rlast = v.bad_rlast; cfg_seed = v.seed;
      do_reset();
      @(negedge clk);
      base_i = v.base; seed_i = v.seed; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(v.poke, seen);
      check($sformatf("v%0d done", n), 64'(seen), 64'd1);
      check($sformatf("v%0d pass", n), 64'(pass), 64'(v.exp_pass));
      check($sformatf("v%0d err_count", n), 64'(err_count), 64'(v.exp_err));
      check($sformatf("v%0d first_err_addr", n), 64'(first_err), 64'(v.exp_first));
      check($sformatf("v%0d done latency", n), 64'(cyc), 64'(r_hs_cyc + 1));
      check($sformatf("v%0d aw count", n), 64'(aw_n), 64'd4);
      for (int b = 0; b < 4; b++) begin
         exp_a = v.base + 16'(b * 1024);
         check($sformatf("v%0d awaddr%0d", n, b), 64'(aw_log[b]), 64'(exp_a));
      end
      check($sformatf("v%0d wdata/wlast", n), 64'(wbad), 64'd0);
      check($sformatf("v%0d stall stability", n), 64'(stall_bad), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d done/busy after", n), 64'({done, busy}), 64'd0);
   endtask

   initial begin
      bit seen;
      //            base      seed          bp crpt crp2 rresp slv rlast poke err first     pass
      vecs[0] = '{16'h0000, 32'h0000_1000, 0, -1, -1, -1, -1, -1, 0, 0, 16'h0000, 1'b1};
      vecs[1] = '{16'h0000, 32'h0000_1000, 1, -1, -1, -1, -1, -1, 0, 0, 16'h0000, 1'b1};
      vecs[2] = '{16'h0000, 32'h0000_1000, 0,  5, -1, -1, -1, -1, 0, 1, 16'h0140, 1'b0};
      vecs[3] = '{16'h0000, 32'h0000_1000, 0, -1, -1, -1,  2,  3, 0, 2, 16'h0800, 1'b0};
      vecs[4] = '{16'hFC00, 32'hDEAD_BEEF, 1, -1, -1, -1, -1, -1, 0, 0, 16'h0000, 1'b1};
      vecs[5] = '{16'h0000, 32'hFFFF_FFF8, 0, 20, -1, 20, -1, -1, 0, 1, 16'h0500, 1'b0};
      vecs[6] = '{16'h2000, 32'h0000_0055, 1, 37, 40, -1, -1, -1, 0, 2, 16'h2940, 1'b0};
      vecs[7] = '{16'h0040, 32'h1234_5678, 0, -1, -1, -1, -1, -1, 1, 0, 16'h0000, 1'b1};
      vecs[8] = '{16'h0000, 32'h0000_0007, 0, -1, -1, -1, -1, 63, 0, 1, 16'h0FC0, 1'b0};

      clear_cfg();
      do_reset();
      rst = 1'b1;
      @(negedge clk);
      check("reset outputs", out_vec(), 64'd0);
      check("aw constants", 64'({axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.awid}),
            64'({8'd15, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0}));
      check("ar constants", 64'({axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arid}),
            64'({8'd15, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0}));
      check("wstrb", 64'(axi.wstrb), {64{1'b1}});
      rst = 1'b0;

      // Start latency, first write beat, then reset in the middle of WR_DATA.
      @(negedge clk);
      cfg_seed = 32'hA5A5_0000;
      base_i = 16'h1200; seed_i = 32'hA5A5_0000; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("busy at t+1", 64'(busy), 64'd1);
      check("awvalid at t+1", 64'(axi.awvalid), 64'd1);
      check("awaddr at t+1", 64'(axi.awaddr), 64'h1200);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (axi.wvalid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("wvalid rises", 64'(seen), 64'd1);
      check("beat0 word lo", 64'(axi.wdata[31:0]), 64'hA5A5_0000);
      check("beat0 word hi", 64'(axi.wdata[511:480]), 64'hA5A5_0000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("outputs after mid-run rst", out_vec(), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      cfg_seed = 32'h0000_1000;
      base_i = 16'h0000; seed_i = 32'h0000_1000; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(0, seen);
      check("rerun done", 64'(seen), 64'd1);
      check("rerun pass", 64'(pass), 64'd1);
      check("rerun err_count", 64'(err_count), 64'd0);
      check("rerun wdata", 64'(wbad), 64'd0);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
